// File: rtl/div_sequencer_if.sv
// Bundle of start request, operands, datapath link and result signals for the
// signed divide sequencer.
//   slave  : the sequencer side (takes requests, drives results and datapath controls)
//   master : the requester/datapath side (drives requests and dp_AQ, observes results)
// Signals:
//   ctrl_DIV, data_operandA, data_operandB : start request and signed operands
//   dp_load, dp_dividend, dp_divisor       : load strobe and held operands to the datapath
//   dp_AQ                                  : datapath state {remainder, unsigned quotient}
//   data_result, data_remainder            : signed quotient and remainder
//   data_exception, data_resultRDY, busy   : status flags
interface div_sequencer_if;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        dp_load;
  logic [31:0] dp_dividend;
  logic [31:0] dp_divisor;
  logic [63:0] dp_AQ;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB, dp_AQ,
    output dp_load, dp_dividend, dp_divisor, data_result, data_remainder,
           data_exception, data_resultRDY, busy
  );

  modport master (
    output ctrl_DIV, data_operandA, data_operandB, dp_AQ,
    input  dp_load, dp_dividend, dp_divisor, data_result, data_remainder,
           data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_sequencer.sv
// Control sequencer for a 32-step iterative signed divider. It latches the
// signed operands, strobes an external unsigned datapath, counts 32 steps,
// then applies the sign rules to the datapath's quotient/remainder magnitudes.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : div_sequencer_if.slave (request, datapath link, results, status)
module div_sequencer (
  input  logic            clock,
  input  logic            reset_n,
  div_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIN, ERR} SeqState;

  SeqState     state;
  SeqState     nextState;
  logic [5:0]  iterCount;
  logic [31:0] dividendReg;
  logic [31:0] divisorReg;
  logic        overflowPair;
  logic [31:0] resultReg;
  logic [31:0] remainderReg;
  logic        exceptionReg;
  logic        resultRdyReg;
  logic        startRequest;
  logic        divByZero;
  logic [31:0] quotMag;
  logic [31:0] remMag;
  logic [31:0] quotSigned;
  logic [31:0] remSigned;

  // Requests only count while idle; a zero divisor skips the datapath entirely.
  assign startRequest = (state == IDLE) && bus.ctrl_DIV;
  assign divByZero    = (bus.data_operandB == 32'd0);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: LOAD for one cycle, RUN for 32 cycles, then a single
  // completion cycle (FIN or ERR) before returning to IDLE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (startRequest) begin
          nextState = divByZero ? ERR : LOAD;
        end
      end
      LOAD: nextState = RUN;
      RUN: begin
        if (iterCount == 6'd31) begin
          nextState = FIN;
        end
      end
      FIN:     nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand latches feed the datapath directly, so they only change on an
  // accepted (non-zero divisor) start. The most-negative / -1 pair is flagged
  // here because its true quotient does not fit in 32 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dividendReg  <= 32'd0;
      divisorReg   <= 32'd0;
      overflowPair <= 1'b0;
    end else if (startRequest && !divByZero) begin
      dividendReg  <= bus.data_operandA;
      divisorReg   <= bus.data_operandB;
      overflowPair <= (bus.data_operandA == 32'h8000_0000) &&
                      (bus.data_operandB == 32'hFFFF_FFFF);
    end
  end

  // Iteration counter: cleared while loading, counts each RUN step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iterCount <= 6'd0;
    end else if (state == LOAD) begin
      iterCount <= 6'd0;
    end else if (state == RUN) begin
      iterCount <= iterCount + 6'd1;
    end
  end

  // Quotient sign follows the XOR of operand signs; remainder takes the
  // dividend's sign (truncating division).
  assign quotMag    = bus.dp_AQ[31:0];
  assign remMag     = bus.dp_AQ[63:32];
  assign quotSigned = (dividendReg[31] ^ divisorReg[31]) ? (~quotMag + 32'd1) : quotMag;
  assign remSigned  = dividendReg[31] ? (~remMag + 32'd1) : remMag;

  // Result registers update only on the completion cycle and otherwise hold;
  // the ready flag is a one-cycle pulse after FIN or ERR.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resultReg    <= 32'd0;
      remainderReg <= 32'd0;
      exceptionReg <= 1'b0;
      resultRdyReg <= 1'b0;
    end else begin
      resultRdyReg <= 1'b0;
      if (state == FIN) begin
        resultReg    <= quotSigned;
        remainderReg <= remSigned;
        exceptionReg <= overflowPair;
        resultRdyReg <= 1'b1;
      end else if (state == ERR) begin
        resultReg    <= 32'd0;
        remainderReg <= 32'd0;
        exceptionReg <= 1'b1;
        resultRdyReg <= 1'b1;
      end
    end
  end

  assign bus.dp_load        = (state == LOAD);
  assign bus.dp_dividend    = dividendReg;
  assign bus.dp_divisor     = divisorReg;
  assign bus.data_result    = resultReg;
  assign bus.data_remainder = remainderReg;
  assign bus.data_exception = exceptionReg;
  assign bus.data_resultRDY = resultRdyReg;
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Testbench for div_sequencer: provides a restoring-division datapath, a
// timeline/arithmetic reference model, a per-cycle compare process, directed
// cases with literal expectations, and a randomized request phase.
module tb_div_sequencer;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  div_sequencer_if divBus();

  div_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (divBus)
  );

  always #5 clock = ~clock;

  int testsRun    = 0;
  int testsFailed = 0;
  bit compareOn   = 1'b0;
  bit dpLoadSeen  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- unsigned restoring-division datapath ----------------
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] divStep(input logic [63:0] aq, input logic [31:0] m);
    logic [64:0] shifted;
    shifted = {aq, 1'b0};
    if (shifted[64:32] >= {1'b0, m}) begin
      shifted[64:32] = shifted[64:32] - {1'b0, m};
      shifted[0] = 1'b1;
    end
    return shifted[63:0];
  endfunction

  logic [63:0] dpState;
  int          stepsLeft;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dpState   <= 64'd0;
      stepsLeft <= 0;
    end else if (divBus.dp_load) begin
      dpState   <= {32'd0, magnitude(divBus.dp_dividend)};
      stepsLeft <= 32;
    end else if (stepsLeft > 0) begin
      dpState   <= divStep(dpState, magnitude(divBus.dp_divisor));
      stepsLeft <= stepsLeft - 1;
    end
  end

  assign divBus.dp_AQ = dpState;

  always @(negedge clock) begin
    if (divBus.dp_load) dpLoadSeen = 1'b1;
  end

  // ---------------- reference model ----------------
  task automatic referenceDivide(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
      e = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      e  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end
  endtask

  int          edgeNum    = 0;
  int          mStartEdge = -100;
  int          mDoneEdge  = -100;
  bit          mZero      = 1'b0;
  logic [31:0] pendQ = '0, pendR = '0;
  logic        pendE = 1'b0;
  logic [31:0] expResult = '0, expRem = '0, expDividend = '0, expDivisor = '0;
  logic        expExc = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mStartEdge  = -100;
      mDoneEdge   = -100;
      mZero       = 1'b0;
      expResult   = '0;
      expRem      = '0;
      expExc      = 1'b0;
      expDividend = '0;
      expDivisor  = '0;
    end else begin
      edgeNum++;
      if (edgeNum == mDoneEdge) begin
        expResult = pendQ;
        expRem    = pendR;
        expExc    = pendE;
      end
      if (divBus.ctrl_DIV && !((edgeNum - 1) >= mStartEdge && (edgeNum - 1) < mDoneEdge)) begin
        referenceDivide(divBus.data_operandA, divBus.data_operandB, pendQ, pendR, pendE);
        mStartEdge = edgeNum;
        mZero      = (divBus.data_operandB == 32'd0);
        mDoneEdge  = edgeNum + (mZero ? 1 : 34);
        if (!mZero) begin
          expDividend = divBus.data_operandA;
          expDivisor  = divBus.data_operandB;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (compareOn) begin
      checkOutput("busy", 32'(divBus.busy), 32'(edgeNum >= mStartEdge && edgeNum < mDoneEdge));
      checkOutput("dpLoad", 32'(divBus.dp_load), 32'(edgeNum == mStartEdge && !mZero));
      checkOutput("resultRDY", 32'(divBus.data_resultRDY), 32'(edgeNum == mDoneEdge));
      checkOutput("result", divBus.data_result, expResult);
      checkOutput("remainder", divBus.data_remainder, expRem);
      checkOutput("exception", 32'(divBus.data_exception), 32'(expExc));
      checkOutput("dpDividend", divBus.dp_dividend, expDividend);
      checkOutput("dpDivisor", divBus.dp_divisor, expDivisor);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int startEdge);
    @(negedge clock);
    #1;
    divBus.ctrl_DIV      = 1'b1;
    divBus.data_operandA = a;
    divBus.data_operandB = b;
    @(posedge clock);
    #1;
    startEdge       = edgeNum;
    divBus.ctrl_DIV = 1'b0;
  endtask

  task automatic waitRdy(input int maxCycles, output int rdyEdge);
    rdyEdge = -1;
    for (int i = 0; i < maxCycles && rdyEdge < 0; i++) begin
      @(negedge clock);
      if (divBus.data_resultRDY) rdyEdge = edgeNum;
    end
    if (rdyEdge < 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL rdyTimeout: no data_resultRDY within %0d cycles", maxCycles);
    end
  endtask

  task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] q, input logic [31:0] r, input logic e, input int lat);
    int s;
    int rdyEdge;
    dpLoadSeen = 1'b0;
    applyStimulus(a, b, s);
    waitRdy(lat + 10, rdyEdge);
    checkOutput({tag, "/latency"}, 32'(rdyEdge - s), 32'(lat));
    checkOutput({tag, "/result"}, divBus.data_result, q);
    checkOutput({tag, "/remainder"}, divBus.data_remainder, r);
    checkOutput({tag, "/exception"}, 32'(divBus.data_exception), 32'(e));
    @(negedge clock);
    checkOutput({tag, "/rdyWidth"}, 32'(divBus.data_resultRDY), 32'd0);
    if (b == 32'd0) checkOutput({tag, "/noLoad"}, 32'(dpLoadSeen), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s;
    int rdyEdge;
    bit rdySeen;

    divBus.ctrl_DIV      = 1'b0;
    divBus.data_operandA = 32'd0;
    divBus.data_operandB = 32'd0;

    @(negedge clock);
    compareOn = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("resetBusy", 32'(divBus.busy), 32'd0);
    checkOutput("resetResult", divBus.data_result, 32'd0);
    checkOutput("resetRdy", 32'(divBus.data_resultRDY), 32'd0);
    checkOutput("resetDividend", divBus.dp_dividend, 32'd0);
    #1 reset_n = 1'b1;

    runDirected("pos100by7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    runDirected("neg100by7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    runDirected("pos100byNeg7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
    runDirected("divByZero", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);
    runDirected("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 34);

    // A second request mid-operation must be ignored.
    applyStimulus(32'd100, 32'd7, s);
    while (edgeNum < s + 9) @(negedge clock);
    #1;
    divBus.ctrl_DIV      = 1'b1;
    divBus.data_operandA = 32'd9;
    divBus.data_operandB = 32'd3;
    @(posedge clock);
    #1 divBus.ctrl_DIV = 1'b0;
    checkOutput("ignored/dividend", divBus.dp_dividend, 32'd100);
    waitRdy(44, rdyEdge);
    checkOutput("ignored/latency", 32'(rdyEdge - s), 32'd34);
    checkOutput("ignored/result", divBus.data_result, 32'd14);
    checkOutput("ignored/remainder", divBus.data_remainder, 32'd2);

    // Asynchronous abort at edge 20, checked before any further clock edge.
    applyStimulus(32'd100, 32'd7, s);
    while (edgeNum < s + 19) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort/busy", 32'(divBus.busy), 32'd0);
    checkOutput("abort/dpLoad", 32'(divBus.dp_load), 32'd0);
    checkOutput("abort/result", divBus.data_result, 32'd0);
    checkOutput("abort/remainder", divBus.data_remainder, 32'd0);
    checkOutput("abort/exception", 32'(divBus.data_exception), 32'd0);
    checkOutput("abort/dividend", divBus.dp_dividend, 32'd0);
    checkOutput("abort/divisor", divBus.dp_divisor, 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    rdySeen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (divBus.data_resultRDY) rdySeen = 1'b1;
    end
    checkOutput("abort/noRdy", 32'(rdySeen), 32'd0);
    runDirected("afterReset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    // Random requests every cycle; the model decides which are accepted.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        divBus.ctrl_DIV = 1'b1;
        case ($urandom_range(0, 7))
          0: begin
            divBus.data_operandA = $urandom;
            divBus.data_operandB = 32'd0;
          end
          1: begin
            divBus.data_operandA = 32'h8000_0000;
            divBus.data_operandB = 32'hFFFF_FFFF;
          end
          2: begin
            divBus.data_operandA = $urandom;
            divBus.data_operandB = 32'($signed($urandom_range(0, 30)) - 15);
          end
          default: begin
            divBus.data_operandA = $urandom;
            divBus.data_operandB = $urandom;
          end
        endcase
      end else begin
        divBus.ctrl_DIV = 1'b0;
      end
    end
    #1 divBus.ctrl_DIV = 1'b0;
    repeat (40) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t, expected below 300000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
